// File: rtl/mem_arbiter_pkg.sv
// Shared type definitions for the memory arbiter: FSM state and requester identity.
package rv32i_types;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_REQ_I = 1'b0,
        ARB_REQ_D = 1'b1
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache fills and
// D-cache fills/writebacks. One transaction in flight; a mandatory IDLE cycle between grants.
//
// state       | meaning
// ARB_IDLE    | no transaction; sample requests and grant at most one
// ARB_SERVE_I | I-cache line fill in flight on pmem, waiting for pmem_resp
// ARB_SERVE_D | D-cache fill or writeback in flight on pmem, waiting for pmem_resp
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    arb_state_t        state;
    arb_state_t        state_next;
    arb_req_t          last_grant;
    arb_req_t          grant_req;
    logic              grant;
    logic              i_pend;
    logic              d_pend;
    logic              op_write;
    logic [ADDR_W-1:0] addr_lat;
    logic [LINE_W-1:0] wdata_lat;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_REQ_I;
            op_write   <= 1'b0;
            addr_lat   <= '0;
            wdata_lat  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                last_grant <= grant_req;
                if (grant_req == ARB_REQ_D) begin
                    // A simultaneous read+write from the D side is a writeback.
                    op_write  <= d_write;
                    addr_lat  <= d_addr & LINE_MASK;
                    wdata_lat <= d_wdata;
                end else begin
                    op_write <= 1'b0;
                    addr_lat <= i_addr & LINE_MASK;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_req  = ARB_REQ_I;
        case (state)
            ARB_IDLE: begin
                if (i_pend && d_pend) begin
                    grant     = 1'b1;
                    grant_req = (last_grant == ARB_REQ_I) ? ARB_REQ_D : ARB_REQ_I;
                end else if (d_pend) begin
                    grant     = 1'b1;
                    grant_req = ARB_REQ_D;
                end else if (i_pend) begin
                    grant     = 1'b1;
                    grant_req = ARB_REQ_I;
                end
                if (grant) begin
                    state_next = (grant_req == ARB_REQ_D) ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (pmem_resp) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            ARB_SERVE_I: begin
                pmem_read  = ~op_write;
                pmem_write = op_write;
                i_resp     = pmem_resp;
            end
            ARB_SERVE_D: begin
                pmem_read  = ~op_write;
                pmem_write = op_write;
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

    assign pmem_addr  = addr_lat;
    assign pmem_wdata = wdata_lat;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;

endmodule
